// File: rtl/sync_debounce_bank.sv
// Multi-channel synchroniser and debouncer: each channel has its own sync chain and stability counter.
// Define DEBOUNCE_EDGE_EN to get registered one-cycle rise/fall pulses; without it they are tied low.
module sync_debounce_bank #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 32768
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [NUM_CH-1:0] d,
  output logic [NUM_CH-1:0] q,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   r_p;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_next;
    logic                   r_q;
    logic                   w_q_next;

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_sync <= '0;
        r_p    <= 1'b0;
        r_cnt  <= '0;
        r_q    <= 1'b0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], d[gi]};
        r_p    <= w_s;
        r_cnt  <= w_cnt_next;
        r_q    <= w_q_next;
      end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // Any change between s and its delayed copy restarts the count; q only loads once saturated.
    always_comb begin
      w_cnt_next = r_cnt;
      w_q_next   = r_q;
      if (w_s != r_p) begin
        w_cnt_next = '0;
      end else if (r_cnt != CNT_MAX) begin
        w_cnt_next = r_cnt + 1'b1;
      end else begin
        w_q_next = w_s;
      end
    end

    assign q[gi] = r_q;

`ifdef DEBOUNCE_EDGE_EN
    logic r_rise;
    logic r_fall;

    always_ff @(posedge Clk) begin
      if (!Reset_n) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= w_q_next & ~r_q;
        r_fall <= ~w_q_next & r_q;
      end
    end

    assign rise[gi] = r_rise;
    assign fall[gi] = r_fall;
`else
    assign rise[gi] = 1'b0;
    assign fall[gi] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sync_debounce_bank.sv
// Directed bench for sync_debounce_bank with NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (latency 8).
// Edge-pulse expectations follow whether DEBOUNCE_EDGE_EN is defined for the build.
module tb_sync_debounce_bank;

`ifdef DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       Clk;
  logic       Reset_n;
  logic [3:0] d;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;

  int n_checks;
  int n_errors;

  sync_debounce_bank #(
    .NUM_CH         (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .d      (d),
    .q      (q),
    .rise   (rise),
    .fall   (fall)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] edge_exp(input logic [3:0] v);
    return EDGE_EN ? v : 4'h0;
  endfunction

  int q_hi;
  int r_cnt;
  int q1_early;

  initial begin
    n_checks = 0;
    n_errors = 0;
    Reset_n  = 1'b0;
    d        = 4'hF;

    // 1: reset with inputs high, then release and measure latency
    tick();
    tick();
    chk("rst_q", q, 4'h0);
    chk("rst_rise", rise, 4'h0);
    chk("rst_fall", fall, 4'h0);
    Reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("s1_q_early", q, 4'h0);
      chk("s1_rise_early", rise, 4'h0);
    end
    tick();
    chk("s1_q_edge8", q, 4'hF);
    chk("s1_rise_edge8", rise, edge_exp(4'hF));
    tick();
    chk("s1_q_edge9", q, 4'hF);
    chk("s1_rise_edge9", rise, 4'h0);

    d = 4'h0;
    for (int e = 1; e <= 7; e++) tick();
    chk("s1_q_fall_edge7", q, 4'hF);
    tick();
    chk("s1_q_fall_edge8", q, 4'h0);
    chk("s1_fall_edge8", fall, edge_exp(4'hF));
    for (int e = 1; e <= 4; e++) tick();
    chk("s1_fall_cleared", fall, 4'h0);

    // 2: 5-cycle pulse is rejected, 6-cycle pulse passes
    q_hi  = 0;
    r_cnt = 0;
    d[0]  = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 5) d[0] = 1'b0;
      if (q[0] === 1'b1) q_hi++;
      if (rise[0] === 1'b1) r_cnt++;
    end
    chk("s2_short_q_hi", q_hi, 0);
    chk("s2_short_rise", r_cnt, 0);

    q_hi  = 0;
    r_cnt = 0;
    d[0]  = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 6) d[0] = 1'b0;
      if (e == 7) chk("s2_long_q_edge7", q[0], 1'b0);
      if (e == 8) chk("s2_long_q_edge8", q[0], 1'b1);
      if (q[0] === 1'b1) q_hi++;
      if (rise[0] === 1'b1) r_cnt++;
    end
    chk("s2_long_q_hi", q_hi, 6);
    chk("s2_long_rise", r_cnt, EDGE_EN ? 1 : 0);

    // 3: bouncing d[1] for 10 cycles, then held high
    q1_early = 0;
    for (int j = 1; j <= 10; j++) begin
      d[1] = (j % 2 == 1);
      tick();
      if (q[1] !== 1'b0) q1_early++;
    end
    d[1] = 1'b1;
    for (int e = 11; e <= 17; e++) begin
      tick();
      if (q[1] !== 1'b0) q1_early++;
    end
    chk("s3_no_early_q1", q1_early, 0);
    tick();
    chk("s3_q_edge18", q, 4'b0010);
    chk("s3_rise_edge18", rise, edge_exp(4'b0010));

    // 4: simultaneous opposite changes on channels 2 and 3
    d = 4'b1000;
    for (int e = 1; e <= 12; e++) tick();
    chk("s4_pre_q", q, 4'b1000);
    d = 4'b0100;
    for (int e = 1; e <= 7; e++) tick();
    chk("s4_q_edge7", q, 4'b1000);
    tick();
    chk("s4_q_edge8", q, 4'b0100);
    chk("s4_rise_edge8", rise, edge_exp(4'b0100));
    chk("s4_fall_edge8", fall, edge_exp(4'b1000));
    tick();
    chk("s4_rise_edge9", rise, 4'h0);
    chk("s4_fall_edge9", fall, 4'h0);

    // 5: reset mid-count loses progress
    d = 4'h0;
    for (int e = 1; e <= 12; e++) tick();
    chk("s5_pre_q", q, 4'h0);
    d[0] = 1'b1;
    for (int e = 1; e <= 4; e++) tick();
    Reset_n = 1'b0;
    tick();
    chk("s5_q_after_rst", q, 4'h0);
    Reset_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      chk("s5_q_early", q, 4'h0);
    end
    tick();
    chk("s5_q_edge8", q, 4'b0001);
    chk("s5_rise_edge8", rise, edge_exp(4'b0001));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
